// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EX bundle, waits for its data-SRAM response on
// memory ops, aligns/extends load data and hands {rf_we,waddr,wdata,pc} to WB.
module mem_stage #(
  parameter int EX2MEM_LEN = 74,
  parameter int MEM2WB_LEN = 70
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  mem_allowin,
  input  logic                  ex_to_mem_valid,
  input  logic [EX2MEM_LEN-1:0] ex_to_mem_zip,
  input  logic                  wb_allowin,
  output logic                  mem_to_wb_valid,
  output logic [MEM2WB_LEN-1:0] mem_to_wb_zip,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic [38:0]           mem_rf_zip
);

  typedef struct packed {
    logic [2:0]  ld_op;
    logic        mem_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_bundle_t;

  typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;

  state_t     state, state_n;
  ex_bundle_t op;
  logic       mem_valid;
  logic       mem_ready_go;
  logic       accept;
  logic       handoff;
  logic       resp_buf_valid;
  logic [31:0] resp_buf;
  logic       is_load;
  logic       rf_we;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] rf_wdata;

  assign mem_valid       = (state != EMPTY);
  assign mem_ready_go    = (state == READY) | ((state == WAIT) & data_sram_data_ok);
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign accept          = ex_to_mem_valid & mem_allowin;
  assign handoff         = mem_to_wb_valid & wb_allowin;

  always_comb begin
    state_n = state;
    if (accept)
      state_n = ex_to_mem_zip[70] ? WAIT : READY;
    else if (handoff)
      state_n = EMPTY;
    else if ((state == WAIT) && data_sram_data_ok)
      state_n = READY;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (accept) op <= ex_bundle_t'(ex_to_mem_zip);
  end

  // Response is parked when WB stalls the data_ok cycle; a stray data_ok outside
  // WAIT (e.g. for an op killed by reset) never touches the buffer.
  always_ff @(posedge clk) begin
    if (!resetn)
      resp_buf_valid <= 1'b0;
    else if (accept || handoff)
      resp_buf_valid <= 1'b0;
    else if ((state == WAIT) && data_sram_data_ok)
      resp_buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if ((state == WAIT) && data_sram_data_ok) resp_buf <= data_sram_rdata;
  end

  // ld_op 5/6 decode as "none", same as 7.
  assign is_load = (op.ld_op <= 3'd4);
  assign rf_we   = op.rf_we & ~(op.mem_req & ~is_load);
  assign ld_word = resp_buf_valid ? resp_buf : data_sram_rdata;
  assign ld_half = op.alu_result[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_byte = ld_word[7:0];
    case (op.alu_result[1:0])
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
  end

  always_comb begin
    rf_wdata = op.alu_result;
    case (op.ld_op)
      3'd0:    rf_wdata = ld_word;
      3'd1:    rf_wdata = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    rf_wdata = {{16{ld_half[15]}}, ld_half};
      3'd3:    rf_wdata = {24'd0, ld_byte};
      3'd4:    rf_wdata = {16'd0, ld_half};
      default: rf_wdata = op.alu_result;
    endcase
  end

  assign mem_to_wb_zip = {rf_we, op.rf_waddr, rf_wdata, op.pc};
  assign mem_rf_zip    = {mem_valid & rf_we,
                          mem_valid & is_load & ~mem_ready_go,
                          op.rf_waddr, rf_wdata};

endmodule
